imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator between fetch and execute. Accepts one
//  32-bit RV instruction per valid/ready handshake. Returns the sign-/zero-extended
//  immediate, its format code and an illegal flag after STAGES register stages.
//  Adds CSR zimm, RV64/RV32 shamt handling, flush and an illegal-instruction counter.
// PARAMETERS
//  DATA_WIDTH  64  immediate width; 32 (RV32) or 64 (RV64) only
//  STAGES      1   number of elastic register stages; 1 or 2 only
//  CNT_WIDTH   16  width of the saturating illegal-instruction counter
// PORTS
//  clk_i         in   1           clock, all state updates on rising edge
//  rst_ni        in   1           asynchronous, active-low reset
//  flush_i       in   1           drop every in-flight entry
//  in_valid_i    in   1           inst_i is valid
//  in_ready_o    out  1           block accepts inst_i this cycle
//  inst_i        in   32          instruction word
//  out_valid_o   out  1           outputs below are valid
//  out_ready_i   in   1           consumer takes the output this cycle
//  inst_o        out  32          instruction passed through, aligned with imme_o
//  imme_o        out  DATA_WIDTH  generated immediate
//  fmt_o         out  3           imm_fmt_e: NONE,I,S,B,U,J,CSR,SHAMT
//  illegal_o     out  1           opcode not decodable for this DATA_WIDTH
//  illegal_cnt_o out  CNT_WIDTH   count of illegal entries delivered, saturating
// BEHAVIOUR
//  Reset: every stage valid=0 and data=0; out_valid_o=0, imme_o=0, fmt_o=NONE,
//   illegal_o=0, inst_o=0, illegal_cnt_o=0. in_ready_o=1 once rst_ni deasserts.
//  Decode is combinational on inst_i; the result is captured into stage 0 on accept.
//  Latency from accept to out_valid_o is exactly STAGES cycles when the consumer is ready.
//  Formats: I = sext(inst[31:20]), for opcodes 0x13, 0x03, 0x67, 0x1b.
//   S = sext({inst[31:25],inst[11:7]}).
//   B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//   U = sext({inst[31:12],12'b0}) for 0x37 and 0x17.
//   J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
//   CSR = zext(inst[19:15]) when opcode 0x73 and funct3[2]=1. Other 0x73 -> NONE, imm 0.
//   SHAMT applies to 0x13 with funct3 001/101: zext(inst[25:20]) on RV64, inst[24:20] on RV32.
//    SHAMT on 0x1b: zext(inst[24:20]).
//   R-type (0x33, 0x3b), 0x0f -> NONE, imm 0, legal.
//  Illegal: inst[1:0]!=2'b11, or an unlisted opcode, or on RV32 any of:
//   opcode 0x1b/0x3b; SHAMT with inst[25]=1. Illegal -> imm 0, fmt NONE, illegal_o=1.
//  Handshake: each stage is an elastic register. A stage loads when it is empty or its
//   downstream consumes in the same cycle.
//   in_ready_o = !flush_i && (stage0 empty || stage0 advancing).
//   With STAGES=2 the block holds 2 entries under backpressure.
//  While out_valid_o=1 && !out_ready_i, all outputs stay stable.
//  Order is preserved; no entry is duplicated or dropped except by flush.
//  flush_i: all valids clear on the next edge. Flush wins over a simultaneous accept
//   and over a simultaneous output handshake. Counter increments only on handshakes
//   that actually complete.
//  illegal_cnt_o increments when out_valid_o && out_ready_i && illegal_o.
//   It saturates at all-ones and is cleared only by reset.
//  Reset asserted mid-operation: immediate return to the reset state, in-flight entries lost.
// STRUCTURE
//  imm_pkg holds: opcode localparams (0x03,0x0f,0x13,0x17,0x1b,0x23,0x33,0x37,0x3b,
//   0x63,0x67,0x6f,0x73), imm_fmt_e enum (3 bits), and the imm_decode_t struct
//   {imm, fmt, illegal, inst}.
//  Sub-module imm_pipe_reg: one elastic stage parametrised on the payload type.
//   Instantiate it STAGES times via generate.
//  Decode is a function in the top module. The counter lives in the top module.
// TESTING
//  0xFFF00093 (addi -1) -> imme_o=0xFFFF_FFFF_FFFF_FFFF, fmt I, out_valid 1 cycle after accept.
//  0x000000E3 (beq imm[11]=1) -> imme_o=0x800, fmt B.
//   0xFE000EE3 -> 0xFFFF_FFFF_FFFF_FFFC.
//  0x800000B7 (lui) -> 0xFFFF_FFFF_8000_0000.
//   0x300FD073 (csrrwi zimm=31) -> 0x1F, fmt CSR.
//   0x03F09093 (slli 63) -> 63, fmt SHAMT on RV64; illegal_o=1 on RV32.
//  STAGES=2, out_ready_i=0: push A,B; in_ready_o drops after B; outputs hold A stably.
//   Release -> A then B on consecutive cycles.
//  Push 0x00000000 three times, then flush_i with one more in flight ->
//   illegal_cnt_o=3, flushed entry never seen; CNT_WIDTH=2 run saturates at 3.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_FENCE     = 7'h0f;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1b;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_OP_32     = 7'h3b;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_JAL       = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM    = 7'h73;

  // NONE must stay at encoding 0 so a cleared payload reads as "no immediate".
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_CSR   = 3'd6,
    FMT_SHAMT = 3'd7
  } imm_fmt_e;

  // Immediate is always carried at full RV64 width; RV32 builds use the low half.
  typedef struct packed {
    logic [63:0] imm;
    imm_fmt_e    fmt;
    logic        illegal;
    logic [31:0] inst;
  } imm_decode_t;

endpackage

// File: rtl/imm_pipe_reg.sv
// One elastic register stage with valid/ready handshake and synchronous flush.
module imm_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic valid_q, valid_d;
  T     data_q,  data_d;

  // Stage can take a new entry when empty or when its current entry leaves.
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next-state: flush empties the stage; data only changes on a real load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with flush and saturating illegal counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STAGES     = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           inst_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           inst_o,
  output logic [DATA_WIDTH-1:0] imme_o,
  output imm_fmt_e              fmt_o,
  output logic                  illegal_o,
  output logic [CNT_WIDTH-1:0]  illegal_cnt_o
);

  localparam bit RV32 = (DATA_WIDTH == 32);

  function automatic imm_decode_t decode(input logic [31:0] inst);
    imm_decode_t r;
    logic [2:0]  f3;
    logic        is_shift;
    logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [11:0] s_raw;
    logic [12:0] b_raw;
    logic [31:0] u_raw;
    logic [20:0] j_raw;
    r        = '0;
    r.inst   = inst;
    f3       = inst[14:12];
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    s_raw    = {inst[31:25], inst[11:7]};
    b_raw    = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u_raw    = {inst[31:12], 12'b0};
    j_raw    = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    i_imm    = 64'($signed(inst[31:20]));
    s_imm    = 64'($signed(s_raw));
    b_imm    = 64'($signed(b_raw));
    u_imm    = 64'($signed(u_raw));
    j_imm    = 64'($signed(j_raw));
    if (inst[1:0] != 2'b11) begin
      r.illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OPC_OP_IMM: begin
          if (is_shift) begin
            if (RV32 && inst[25]) begin
              r.illegal = 1'b1;
            end else begin
              r.fmt = FMT_SHAMT;
              r.imm = RV32 ? 64'(inst[24:20]) : 64'(inst[25:20]);
            end
          end else begin
            r.fmt = FMT_I;
            r.imm = i_imm;
          end
        end
        OPC_LOAD, OPC_JALR: begin
          r.fmt = FMT_I;
          r.imm = i_imm;
        end
        OPC_OP_IMM_32: begin
          if (RV32) begin
            r.illegal = 1'b1;
          end else if (is_shift) begin
            r.fmt = FMT_SHAMT;
            r.imm = 64'(inst[24:20]);
          end else begin
            r.fmt = FMT_I;
            r.imm = i_imm;
          end
        end
        OPC_STORE: begin
          r.fmt = FMT_S;
          r.imm = s_imm;
        end
        OPC_BRANCH: begin
          r.fmt = FMT_B;
          r.imm = b_imm;
        end
        OPC_LUI, OPC_AUIPC: begin
          r.fmt = FMT_U;
          r.imm = u_imm;
        end
        OPC_JAL: begin
          r.fmt = FMT_J;
          r.imm = j_imm;
        end
        OPC_SYSTEM: begin
          if (f3[2]) begin
            r.fmt = FMT_CSR;
            r.imm = 64'(inst[19:15]);
          end
        end
        OPC_OP, OPC_FENCE: begin
          r.fmt = FMT_NONE;
        end
        OPC_OP_32: begin
          r.illegal = RV32;
        end
        default: begin
          r.illegal = 1'b1;
        end
      endcase
    end
    return r;
  endfunction

  imm_decode_t dec;
  imm_decode_t s0_data;
  imm_decode_t out_data;
  logic        s0_valid;
  logic        s0_ready;
  logic        s0_ds_ready;
  logic        out_valid;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Combinational decode of the incoming instruction.
  always_comb begin
    dec = decode(inst_i);
  end

  assign in_ready_o = !flush_i && s0_ready;

  imm_pipe_reg #(.T(imm_decode_t)) u_stage0 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (in_valid_i),
    .ready_o (s0_ready),
    .data_i  (dec),
    .valid_o (s0_valid),
    .ready_i (s0_ds_ready),
    .data_o  (s0_data)
  );

  // Second stage is chained explicitly so each handshake signal stays a distinct net.
  if (STAGES == 2) begin : g_two
    imm_pipe_reg #(.T(imm_decode_t)) u_stage1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .valid_i (s0_valid),
      .ready_o (s0_ds_ready),
      .data_i  (s0_data),
      .valid_o (out_valid),
      .ready_i (out_ready_i),
      .data_o  (out_data)
    );
  end else begin : g_one
    assign s0_ds_ready = out_ready_i;
    assign out_valid   = s0_valid;
    assign out_data    = s0_data;
  end

  if (DATA_WIDTH < 64) begin : g_narrow
    logic unused_imm_hi;
    assign unused_imm_hi = ^out_data.imm[63:DATA_WIDTH];
  end

  assign out_valid_o   = out_valid;
  assign inst_o        = out_data.inst;
  assign imme_o        = out_data.imm[DATA_WIDTH-1:0];
  assign fmt_o         = out_data.fmt;
  assign illegal_o     = out_data.illegal;
  assign illegal_cnt_o = cnt_q;

  // Count illegal entries on completed output handshakes; flush cancels the handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready_i && out_data.illegal && !flush_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench: RV64/1-stage instance and RV32/2-stage/2-bit-counter instance.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: RV64, one stage, 16-bit counter
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal;
  logic [31:0] a_inst, a_inst_o;
  logic [63:0] a_imme;
  imm_fmt_e    a_fmt;
  logic [15:0] a_cnt;

  // Instance B: RV32, two stages, 2-bit counter
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal;
  logic [31:0] b_inst, b_inst_o;
  logic [31:0] b_imme;
  imm_fmt_e    b_fmt;
  logic [1:0]  b_cnt;

  imm_gen_pipe #(.DATA_WIDTH(64), .STAGES(1), .CNT_WIDTH(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .inst_i(a_inst),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .inst_o(a_inst_o),
    .imme_o(a_imme), .fmt_o(a_fmt), .illegal_o(a_illegal), .illegal_cnt_o(a_cnt)
  );

  imm_gen_pipe #(.DATA_WIDTH(32), .STAGES(2), .CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .inst_i(b_inst),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .inst_o(b_inst_o),
    .imme_o(b_imme), .fmt_o(b_fmt), .illegal_o(b_illegal), .illegal_cnt_o(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single transaction on A with the consumer ready; output must appear one cycle after accept.
  task automatic a_push(input string tag, input logic [31:0] inst, input logic [63:0] imm,
                        input imm_fmt_e fmt, input logic ill);
    @(negedge clk);
    a_inst = inst; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, "_imm"}, a_imme, imm);
    chk({tag, "_fmt"}, 64'(a_fmt), 64'(fmt));
    chk({tag, "_ill"}, 64'(a_illegal), 64'(ill));
    chk({tag, "_inst"}, 64'(a_inst_o), 64'(inst));
  endtask

  // Single transaction on B with the consumer ready; output appears two cycles after accept.
  task automatic b_push(input string tag, input logic [31:0] inst, input logic [31:0] imm,
                        input imm_fmt_e fmt, input logic ill);
    @(negedge clk);
    b_inst = inst; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    chk({tag, "_early"}, 64'(b_out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid"}, 64'(b_out_valid), 64'd1);
    chk({tag, "_imm"}, 64'(b_imme), 64'(imm));
    chk({tag, "_fmt"}, 64'(b_fmt), 64'(fmt));
    chk({tag, "_ill"}, 64'(b_illegal), 64'(ill));
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_inst = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_inst = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_imm",   a_imme, 64'd0);
    chk("rst_a_fmt",   64'(a_fmt), 64'(FMT_NONE));
    chk("rst_a_ill",   64'(a_illegal), 64'd0);
    chk("rst_a_inst",  64'(a_inst_o), 64'd0);
    chk("rst_a_cnt",   64'(a_cnt), 64'd0);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_a_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_ready", 64'(b_in_ready), 64'd1);

    // RV64 decode vectors
    a_push("addi_m1", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I,     1'b0);
    a_push("beq_800", 32'h000000E3, 64'h0000_0000_0000_0800, FMT_B,     1'b0);
    a_push("beq_m4",  32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B,     1'b0);
    a_push("lui",     32'h800000B7, 64'hFFFF_FFFF_8000_0000, FMT_U,     1'b0);
    a_push("csrrwi",  32'h300FD073, 64'h0000_0000_0000_001F, FMT_CSR,   1'b0);
    a_push("slli63",  32'h03F09093, 64'd63,                  FMT_SHAMT, 1'b0);
    a_push("sw_m4",   32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S,     1'b0);
    a_push("jal_neg", 32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, FMT_J,     1'b0);
    a_push("add",     32'h00B50533, 64'd0,                   FMT_NONE,  1'b0);
    a_push("csrrw",   32'h30029073, 64'd0,                   FMT_NONE,  1'b0);
    a_push("zero",    32'h00000000, 64'd0,                   FMT_NONE,  1'b1);
    @(negedge clk);
    chk("a_cnt_1", 64'(a_cnt), 64'd1);

    // Asynchronous reset while an entry is valid at the output
    a_inst = 32'hFFF00093; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(posedge clk); #2;
    chk("mid_rst_pre", 64'(a_out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_imm",   a_imme, 64'd0);
    chk("mid_rst_cnt",   64'(a_cnt), 64'd0);
    @(negedge clk);
    a_in_valid = 1'b0;
    rst_n = 1'b1;

    // Three illegal entries delivered, a fourth flushed while stalled
    a_push("ill0", 32'h00000000, 64'd0, FMT_NONE, 1'b1);
    a_push("ill1", 32'h00000000, 64'd0, FMT_NONE, 1'b1);
    a_push("ill2", 32'h00000000, 64'd0, FMT_NONE, 1'b1);
    @(negedge clk);
    chk("a_cnt_3", 64'(a_cnt), 64'd3);
    a_inst = 32'h00000000; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("fl_pending", 64'(a_out_valid), 64'd1);
    a_flush = 1'b1; a_out_ready = 1'b1; a_inst = 32'hFFF00093;
    #1 chk("fl_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_cnt",   64'(a_cnt), 64'd3);
    @(negedge clk);
    chk("fl_valid2", 64'(a_out_valid), 64'd0);
    chk("fl_cnt2",   64'(a_cnt), 64'd3);

    // RV32, two stages
    b_push("b_addi",   32'hFFF00093, 32'hFFFF_FFFF, FMT_I,     1'b0);
    b_push("b_slli63", 32'h03F09093, 32'd0,         FMT_NONE,  1'b1);
    b_push("b_op32",   32'h0000003B, 32'd0,         FMT_NONE,  1'b1);
    b_push("b_lui",    32'h800000B7, 32'h8000_0000, FMT_U,     1'b0);
    b_push("b_slli31", 32'h01F09093, 32'd31,        FMT_SHAMT, 1'b0);
    @(negedge clk);
    chk("b_cnt_2", 64'(b_cnt), 64'd2);

    // Backpressure: two entries held, outputs stable, then drained in order
    b_out_ready = 1'b0; b_inst = 32'h00100093; b_in_valid = 1'b1;
    #1 chk("bp_rdy_a", 64'(b_in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    b_inst = 32'h00200093;
    #1 chk("bp_rdy_b", 64'(b_in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    #1 chk("bp_full", 64'(b_in_ready), 64'd0);
    chk("bp_valid_a", 64'(b_out_valid), 64'd1);
    chk("bp_imm_a",   64'(b_imme), 64'd1);
    chk("bp_inst_a",  64'(b_inst_o), 64'h00100093);
    @(posedge clk); @(negedge clk);
    chk("bp_hold_valid", 64'(b_out_valid), 64'd1);
    chk("bp_hold_imm",   64'(b_imme), 64'd1);
    chk("bp_hold_inst",  64'(b_inst_o), 64'h00100093);
    chk("bp_hold_rdy",   64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_valid_b", 64'(b_out_valid), 64'd1);
    chk("bp_imm_b",   64'(b_imme), 64'd2);
    chk("bp_inst_b",  64'(b_inst_o), 64'h00200093);
    @(posedge clk); @(negedge clk);
    chk("bp_empty", 64'(b_out_valid), 64'd0);

    // Saturation: three more illegal entries on a 2-bit counter already at 2
    b_inst = 32'h00000000; b_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_cnt_sat", 64'(b_cnt), 64'd3);
    chk("b_drained", 64'(b_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
